// File: rtl/game_master.sv
// Master-board (P1) bingo controller: owns the P1 map/marks, sequences the two-board game protocol.
// Latency: one send strobe on the cycle after the triggering event; P1_CHECK adds one cycle after a P1 guess.
// Backpressure: every SEND_* state holds transmit high until inter_ready, and no other input is consumed meanwhile.
`ifndef STATE_TURN
`define STATE_TURN 3'd1
`endif
`ifndef SEL_NUM
`define SEL_NUM 3'd2
`endif
`ifndef STATE_WIN
`define STATE_WIN 3'd3
`endif

module game_master #(
    parameter int WIN_LINES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         interboard_rst,
    input  logic         start_pulse,
    input  logic [7:0]   cur_number_BCD,
    input  logic         enter_pulse,
    input  logic         inter_ready,
    input  logic         interboard_en,
    input  logic [2:0]   interboard_msg_type,
    input  logic [4:0]   interboard_number,
    output logic         transmit,
    output logic         ctrl_en,
    output logic [2:0]   ctrl_msg_type,
    output logic [4:0]   ctrl_number,
    output logic [124:0] map,
    output logic [24:0]  circle,
    output logic [1:0]   game_result
);

    typedef enum logic [3:0] {
        IDLE,
        SEND_INIT,
        P1_SEL,
        SEND_SEL_DONE,
        WAIT_P2_SEL,
        P1_GUESS,
        P1_CHECK,
        SEND_GUESS,
        SEND_WIN,
        WAIT_P2_GUESS,
        FIN,
        SEND_RESTART
    } state_t;

    state_t     state;
    logic [4:0] sel_cnt;
    logic [4:0] guess_num;

    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] entry_n;
    logic [4:0] entry_num;
    logic       entry_ok;
    logic       entry_hit;
    logic [4:0] entry_pos;
    logic       rx_ok;
    logic       rx_hit;
    logic [4:0] rx_pos;
    logic [11:0] line_done;
    logic [3:0] line_cnt;
    logic       i_win;

    assign tens      = cur_number_BCD[7:4];
    assign ones      = cur_number_BCD[3:0];
    assign entry_n   = {3'b000, tens} * 7'd10 + {3'b000, ones};
    assign entry_num = entry_n[4:0];
    assign entry_ok  = (tens <= 4'd9) && (ones <= 4'd9) && (entry_n != 7'd0) && (entry_n <= 7'd25);
    assign rx_ok     = (interboard_number != 5'd0) && (interboard_number <= 5'd25);

    // Unfilled slots hold 0, which never matches a valid number (1..25).
    always_comb begin
        entry_hit = 1'b0;
        entry_pos = 5'd0;
        rx_hit    = 1'b0;
        rx_pos    = 5'd0;
        for (int p = 0; p < 25; p++) begin
            if (map[5*p +: 5] == entry_num) begin
                entry_hit = 1'b1;
                entry_pos = 5'(p);
            end
            if (map[5*p +: 5] == interboard_number) begin
                rx_hit = 1'b1;
                rx_pos = 5'(p);
            end
        end
    end

    always_comb begin
        line_done = '0;
        for (int r = 0; r < 5; r++) begin
            line_done[r] = &circle[5*r +: 5];
        end
        for (int c = 0; c < 5; c++) begin
            line_done[5+c] = 1'b1;
            for (int r = 0; r < 5; r++) begin
                line_done[5+c] = line_done[5+c] & circle[5*r+c];
            end
        end
        line_done[10] = 1'b1;
        line_done[11] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            line_done[10] = line_done[10] & circle[6*i];
            line_done[11] = line_done[11] & circle[4*i+4];
        end
        line_cnt = 4'd0;
        for (int i = 0; i < 12; i++) begin
            line_cnt = line_cnt + {3'b000, line_done[i]};
        end
    end

    assign i_win = (32'(line_cnt) >= WIN_LINES);

    task automatic start_send(input logic [2:0] msg_type, input logic [4:0] number);
        ctrl_en       <= 1'b1;
        transmit      <= 1'b1;
        ctrl_msg_type <= msg_type;
        ctrl_number   <= number;
    endtask

    always_ff @(posedge clk) begin
        if (rst || interboard_rst) begin
            state         <= IDLE;
            sel_cnt       <= 5'd0;
            guess_num     <= 5'd0;
            map           <= '0;
            circle        <= '0;
            game_result   <= 2'd0;
            transmit      <= 1'b0;
            ctrl_en       <= 1'b0;
            ctrl_msg_type <= 3'h7;
            ctrl_number   <= 5'd0;
        end else begin
            ctrl_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_pulse) begin
                        state <= SEND_INIT;
                        start_send(`STATE_TURN, 5'd0);
                    end
                end
                SEND_INIT: begin
                    if (inter_ready) begin
                        transmit <= 1'b0;
                        state    <= P1_SEL;
                    end
                end
                P1_SEL: begin
                    if (enter_pulse && entry_ok && !entry_hit) begin
                        map[5*sel_cnt +: 5] <= entry_num;
                        sel_cnt             <= sel_cnt + 5'd1;
                        if (sel_cnt == 5'd24) begin
                            state <= SEND_SEL_DONE;
                            start_send(`STATE_TURN, 5'd0);
                        end
                    end
                end
                SEND_SEL_DONE: begin
                    if (inter_ready) begin
                        transmit <= 1'b0;
                        state    <= WAIT_P2_SEL;
                    end
                end
                WAIT_P2_SEL: begin
                    if (interboard_en && interboard_msg_type == `STATE_TURN) begin
                        state <= P1_GUESS;
                    end
                end
                P1_GUESS: begin
                    if (i_win) begin
                        state <= SEND_WIN;
                        start_send(`STATE_WIN, 5'd0);
                    end else if (enter_pulse && entry_ok && entry_hit && !circle[entry_pos]) begin
                        circle[entry_pos] <= 1'b1;
                        guess_num         <= entry_num;
                        state             <= P1_CHECK;
                    end
                end
                P1_CHECK: begin
                    if (i_win) begin
                        state <= SEND_WIN;
                        start_send(`STATE_WIN, 5'd0);
                    end else begin
                        state <= SEND_GUESS;
                        start_send(`SEL_NUM, guess_num);
                    end
                end
                SEND_GUESS: begin
                    if (inter_ready) begin
                        transmit <= 1'b0;
                        state    <= WAIT_P2_GUESS;
                    end
                end
                SEND_WIN: begin
                    if (inter_ready) begin
                        transmit    <= 1'b0;
                        game_result <= 2'd1;
                        state       <= FIN;
                    end
                end
                WAIT_P2_GUESS: begin
                    if (interboard_en) begin
                        if (interboard_msg_type == `SEL_NUM && rx_ok) begin
                            if (rx_hit) begin
                                circle[rx_pos] <= 1'b1;
                            end
                            state <= P1_GUESS;
                        end else if (interboard_msg_type == `STATE_WIN) begin
                            game_result <= 2'd2;
                            state       <= FIN;
                        end
                    end
                end
                FIN: begin
                    if (start_pulse) begin
                        map         <= '0;
                        circle      <= '0;
                        sel_cnt     <= 5'd0;
                        game_result <= 2'd0;
                        state       <= SEND_RESTART;
                        start_send(`STATE_TURN, 5'd0);
                    end
                end
                SEND_RESTART: begin
                    if (inter_ready) begin
                        transmit <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
